// File: rtl/pe_simd_row.sv
// One row of a SIMD processing element: an ifmap scratchpad shared by N_LANES output
// channels, each with its own weight taps and accumulator, drained one lane per beat.
module pe_simd_row #(
    parameter int DATA_BITWIDTH = 8,
    parameter int N_LANES       = 4,
    parameter int ACC_BITWIDTH  = 32,
    parameter int S_MAX         = 15,
    parameter int IFMAP_DEPTH   = 16
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [2:0]                         i_inst_data,
    input  logic [7:0]                         i_conv_info,
    input  logic                               i_inst_valid,
    output logic                               o_inst_ready,
    output logic                               o_inst_err,
    input  logic [DATA_BITWIDTH-1:0]           i_ifmap_data,
    input  logic                               i_ifmap_valid,
    output logic                               o_ifmap_ready,
    input  logic [N_LANES*DATA_BITWIDTH-1:0]   i_wght_data,
    input  logic                               i_wght_valid,
    output logic                               o_wght_ready,
    input  logic [ACC_BITWIDTH-1:0]            i_psum_in_data,
    input  logic                               i_psum_in_valid,
    output logic                               o_psum_in_ready,
    output logic [ACC_BITWIDTH-1:0]            o_psum_out_data,
    output logic                               o_psum_out_valid,
    input  logic                               i_psum_out_ready
);
    localparam int IA_W   = $clog2(IFMAP_DEPTH);
    localparam int WA_W   = $clog2(S_MAX + 1);
    localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_LD_W     = 3'd1;
    localparam logic [2:0] OP_LD_I     = 3'd2;
    localparam logic [2:0] OP_COMP     = 3'd3;
    localparam logic [2:0] OP_COMP_ACC = 3'd4;

    typedef enum logic [2:0] {ST_IDLE, ST_LD_W, ST_LD_I, ST_PSUM_IN, ST_MAC, ST_DRAIN} state_t;

    state_t state_reg, state_next;

    logic [2:0]              op_reg;
    logic [3:0]              s_reg, e_reg, e_idx_reg;
    logic [4:0]              cnt_reg;
    logic [LANE_W-1:0]       lane_reg;
    logic                    err_reg;
    logic [ACC_BITWIDTH-1:0] acc_reg [N_LANES];

    logic [N_LANES*DATA_BITWIDTH-1:0] wght_mem  [S_MAX];
    logic [DATA_BITWIDTH-1:0]         ifmap_mem [IFMAP_DEPTH];

    // Instruction decode straight off the input bus; only used in IDLE.
    logic [3:0] in_s, in_e;
    logic [5:0] in_span;
    logic       uses_e, is_reserved, is_zero, inst_err, inst_go;

    assign in_s        = i_conv_info[3:0];
    assign in_e        = i_conv_info[7:4];
    assign in_span     = {2'b00, in_s} + {2'b00, in_e} - 6'd1;
    assign uses_e      = (i_inst_data == OP_LD_I) || (i_inst_data == OP_COMP) ||
                         (i_inst_data == OP_COMP_ACC);
    assign is_reserved = (i_inst_data > OP_COMP_ACC);
    // LOAD_WGHT has no use for E, so only S gates it into a no-op.
    assign is_zero     = (in_s == 4'd0) || (uses_e && (in_e == 4'd0));
    assign inst_err    = is_reserved ||
                         ((i_inst_data != OP_NOP) && ({1'b0, in_s} > 5'(S_MAX))) ||
                         (uses_e && !is_zero && (in_span > 6'(IFMAP_DEPTH)));
    assign inst_go     = !inst_err && !is_zero && (i_inst_data != OP_NOP);

    logic inst_fire, wght_fire, ifmap_fire, psum_in_fire, psum_out_fire;
    assign inst_fire     = i_inst_valid    && o_inst_ready;
    assign wght_fire     = i_wght_valid    && o_wght_ready;
    assign ifmap_fire    = i_ifmap_valid   && o_ifmap_ready;
    assign psum_in_fire  = i_psum_in_valid && o_psum_in_ready;
    assign psum_out_fire = o_psum_out_valid && i_psum_out_ready;

    logic tap_last, ld_i_last, lane_last, e_last;
    assign tap_last  = (cnt_reg[3:0] == s_reg - 4'd1);
    assign ld_i_last = (cnt_reg == {1'b0, s_reg} + {1'b0, e_reg} - 5'd2);
    assign lane_last = (lane_reg == LANE_W'(N_LANES - 1));
    assign e_last    = (e_idx_reg == e_reg - 4'd1);

    // Datapath: one shared ifmap element times every lane's weight for the current tap.
    logic [DATA_BITWIDTH-1:0]         ifmap_rd;
    logic [N_LANES*DATA_BITWIDTH-1:0] wght_rd;
    logic signed [ACC_BITWIDTH-1:0]   prod_ext [N_LANES];

    assign ifmap_rd = ifmap_mem[IA_W'(e_idx_reg) + IA_W'(cnt_reg)];
    assign wght_rd  = wght_mem[cnt_reg[WA_W-1:0]];

    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
            logic signed [2*DATA_BITWIDTH-1:0] prod;
            assign prod         = $signed(ifmap_rd) * $signed(wght_rd[gi*DATA_BITWIDTH +: DATA_BITWIDTH]);
            assign prod_ext[gi] = ACC_BITWIDTH'(prod);
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_rst) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (inst_fire && inst_go) begin
                    case (i_inst_data)
                        OP_LD_W:     state_next = ST_LD_W;
                        OP_LD_I:     state_next = ST_LD_I;
                        OP_COMP:     state_next = ST_MAC;
                        default:     state_next = ST_PSUM_IN;
                    endcase
                end
            end
            ST_LD_W:    if (wght_fire && tap_last)     state_next = ST_IDLE;
            ST_LD_I:    if (ifmap_fire && ld_i_last)   state_next = ST_IDLE;
            ST_PSUM_IN: if (psum_in_fire && lane_last) state_next = ST_MAC;
            ST_MAC:     if (tap_last)                  state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (psum_out_fire && lane_last) begin
                    if (e_last)                     state_next = ST_IDLE;
                    else if (op_reg == OP_COMP_ACC) state_next = ST_PSUM_IN;
                    else                            state_next = ST_MAC;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_inst_ready     = (state_reg == ST_IDLE);
        o_wght_ready     = (state_reg == ST_LD_W);
        o_ifmap_ready    = (state_reg == ST_LD_I);
        o_psum_in_ready  = (state_reg == ST_PSUM_IN);
        o_psum_out_valid = (state_reg == ST_DRAIN);
        o_psum_out_data  = (state_reg == ST_DRAIN) ? acc_reg[lane_reg] : '0;
        o_inst_err       = err_reg;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            op_reg    <= OP_NOP;
            s_reg     <= '0;
            e_reg     <= '0;
            e_idx_reg <= '0;
            cnt_reg   <= '0;
            lane_reg  <= '0;
            err_reg   <= 1'b0;
            for (int l = 0; l < N_LANES; l++) acc_reg[l] <= '0;
        end else begin
            err_reg <= inst_fire && inst_err;
            case (state_reg)
                ST_IDLE: begin
                    if (inst_fire) begin
                        op_reg    <= i_inst_data;
                        s_reg     <= in_s;
                        e_reg     <= in_e;
                        e_idx_reg <= '0;
                        cnt_reg   <= '0;
                        lane_reg  <= '0;
                        if (inst_go && i_inst_data == OP_COMP)
                            for (int l = 0; l < N_LANES; l++) acc_reg[l] <= '0;
                    end
                end
                ST_LD_W:  if (wght_fire)  cnt_reg <= cnt_reg + 5'd1;
                ST_LD_I:  if (ifmap_fire) cnt_reg <= cnt_reg + 5'd1;
                ST_PSUM_IN: begin
                    if (psum_in_fire) begin
                        acc_reg[lane_reg] <= i_psum_in_data;
                        lane_reg          <= lane_last ? '0 : lane_reg + LANE_W'(1);
                    end
                end
                ST_MAC: begin
                    for (int l = 0; l < N_LANES; l++) acc_reg[l] <= acc_reg[l] + prod_ext[l];
                    cnt_reg <= tap_last ? 5'd0 : cnt_reg + 5'd1;
                end
                ST_DRAIN: begin
                    if (psum_out_fire) begin
                        lane_reg <= lane_last ? '0 : lane_reg + LANE_W'(1);
                        if (lane_last) begin
                            e_idx_reg <= e_idx_reg + 4'd1;
                            if (!e_last && op_reg == OP_COMP)
                                for (int l = 0; l < N_LANES; l++) acc_reg[l] <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Scratchpads are deliberately outside reset so loaded data survives an abort.
    always_ff @(posedge i_clk) begin
        if (wght_fire)  wght_mem[cnt_reg[WA_W-1:0]]  <= i_wght_data;
        if (ifmap_fire) ifmap_mem[cnt_reg[IA_W-1:0]] <= i_ifmap_data;
    end

endmodule
